// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset vector, NOP encoding
// and the fetch FSM state type.
package cpu_pkg;

  localparam int unsigned     ADDR     = 32;
  localparam logic [ADDR-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [ADDR-1:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// Synchronous FIFO with flush and simultaneous push/pop; the read port keeps
// showing the last head value once the FIFO runs empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned   PW      = $clog2(DEPTH);
  localparam logic [PW:0]   FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_q;
  logic             not_empty;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (count != '0);
  assign do_pop    = pop && not_empty;
  assign do_push   = push && ((count != FULL) || do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (not_empty)
        last_q <= mem[rd_ptr];
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push)
          wr_ptr <= wr_ptr + PTR_ONE;
        if (do_pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        case ({do_push, do_pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem[wr_ptr] <= wdata;
  end

  assign rdata = not_empty ? mem[rd_ptr] : last_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues 1-cycle-latency IMEM
// reads and buffers {word, pc} pairs for decode over valid/ready.
module inst_fetch_queue #(
  parameter int unsigned     ADDR     = cpu_pkg::ADDR,
  parameter int unsigned     IMEM_AW  = 6,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [ADDR-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   hold,
  input  logic                   redirect,
  input  logic [ADDR-1:0]        redirect_pc,
  output logic                   imem_req,
  output logic [IMEM_AW-1:0]     imem_addr,
  input  logic [ADDR-1:0]        imem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [ADDR-1:0]        inst_code,
  output logic [ADDR-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  import cpu_pkg::*;

  localparam int unsigned     CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR-1:0] PC_STEP = ADDR'(4);
  localparam logic [ADDR-1:0] PC_MASK = ~ADDR'(3);

  fetch_state_t      state;
  fetch_state_t      state_nx;
  logic [ADDR-1:0]   fetch_pc;
  logic [ADDR-1:0]   req_pc;
  logic              inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic [CW-1:0]     occupancy;
  logic [2*ADDR-1:0] head;

  // An outstanding read always owns a FIFO slot, so push can never overflow.
  assign occupancy = fifo_count + CW'(inflight);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= BOOT;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      BOOT: state_nx = hold ? HOLD : RUN;
      RUN: begin
        if (hold)
          state_nx = HOLD;
        issue = !redirect && (occupancy < DEPTH_C);
      end
      HOLD: begin
        if (!hold)
          state_nx = RUN;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect) begin
        fetch_pc <= redirect_pc & PC_MASK;
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
        req_pc   <= fetch_pc;
      end
    end
  end

  // A response landing in the redirect cycle belongs to the old stream: kill it.
  assign push       = inflight && !redirect;
  assign inst_valid = (fifo_count != '0) && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign imem_req   = issue;
  assign imem_addr  = fetch_pc[IMEM_AW+1:2];

  sync_fifo #(
    .WIDTH (2*ADDR),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect),
    .push  (push),
    .wdata ({imem_rdata, req_pc}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count)
  );

  assign {inst_code, inst_pc} = head;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based reference model plus
// directed scenarios and a randomized run.
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hold = 1'b0;
  logic        redirect = 1'b0;
  logic        inst_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_code;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  logic        w_req;
  logic [5:0]  w_addr;
  logic [31:0] w_rdata = '0;
  logic        w_valid;
  logic [31:0] w_code;
  logic [31:0] w_pc;
  logic [2:0]  w_count;

  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_fetch_queue #(
    .ADDR(32), .IMEM_AW(6), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
  ) dut (
    .clk(clk), .reset(reset), .hold(hold), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_code(inst_code), .inst_pc(inst_pc), .fifo_count(fifo_count)
  );

  inst_fetch_queue #(
    .ADDR(32), .IMEM_AW(6), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)
  ) dut_w (
    .clk(clk), .reset(reset), .hold(1'b0), .redirect(1'b0),
    .redirect_pc(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .inst_valid(w_valid), .inst_ready(1'b1),
    .inst_code(w_code), .inst_pc(w_pc), .fifo_count(w_count)
  );

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem[imem_addr];
    if (w_req)    w_rdata    <= mem[w_addr];
  end

  // Reference model: a queue of {code, pc} plus the fetch PC and one pending read.
  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
  } ent_t;

  ent_t        q[$];
  ent_t        m_last = '0;
  logic [31:0] m_pc = 32'h0;
  logic [31:0] m_fly_pc = 32'h0;
  bit          m_fly = 1'b0;
  bit          m_boot = 1'b0;
  bit          m_hold_last = 1'b0;

  function automatic bit exp_req();
    return m_boot && !m_hold_last && !redirect && ((q.size() + int'(m_fly)) < DEPTH);
  endfunction

  function automatic bit exp_valid();
    return (q.size() != 0) && !redirect;
  endfunction

  function automatic ent_t exp_head();
    return (q.size() != 0) ? q[0] : m_last;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit req;
    bit pop;
    if (!reset) begin
      q.delete();
      m_last = '0;
      m_pc = 32'h0;
      m_fly = 1'b0;
      m_boot = 1'b0;
      m_hold_last = 1'b0;
    end else begin
      req = exp_req();
      pop = exp_valid() && inst_ready;
      if (q.size() != 0) m_last = q[0];
      if (redirect) begin
        q.delete();
        m_fly = 1'b0;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (pop) void'(q.pop_front());
        if (m_fly) q.push_back('{code: mem[m_fly_pc[7:2]], pc: m_fly_pc});
        if (req) begin
          m_fly_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end
        m_fly = req;
      end
      m_boot = 1'b1;
      m_hold_last = hold;
    end
  end

  task automatic step(input bit h, input bit rd, input bit rdr, input logic [31:0] rpc);
    @(negedge clk);
    hold = h;
    inst_ready = rd;
    redirect = rdr;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic test_reset();
    int lat;
    hold = 1'b0; redirect = 1'b0; inst_ready = 1'b1; reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    checks++; if (inst_code !== 32'h0) begin errors++; $display("FAIL rst_code got %h exp 0", inst_code); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", inst_pc); end
    @(negedge clk);
    reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk); #1;
      if (inst_valid) lat = k;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL first_valid_edge got %0d exp 3", lat); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h exp 0", inst_pc); end
  endtask

  task automatic test_stream();
    ent_t e;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      e = exp_head();
      checks++; if (imem_req !== exp_req()) begin errors++; $display("FAIL stream_req got %b exp %b", imem_req, exp_req()); end
      checks++; if (inst_valid !== exp_valid()) begin errors++; $display("FAIL stream_valid got %b exp %b", inst_valid, exp_valid()); end
      checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL stream_pc got %h exp %h", inst_pc, e.pc); end
      checks++; if (inst_code !== e.code) begin errors++; $display("FAIL stream_code got %h exp %h", inst_code, e.code); end
      if (exp_req()) begin
        checks++; if (imem_addr !== m_pc[7:2]) begin errors++; $display("FAIL stream_addr got %0d exp %0d", imem_addr, m_pc[7:2]); end
      end
    end
  endtask

  task automatic test_backpressure();
    ent_t e;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL bp_count got %0d exp %0d", fifo_count, q.size()); end
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL bp_saturate got %0d exp 4", fifo_count); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_stop got %b exp 0", imem_req); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      e = exp_head();
      checks++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid got %b exp 1", inst_valid); end
      checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL bp_drain_pc got %h exp %h", inst_pc, e.pc); end
    end
  endtask

  task automatic test_redirect();
    int n;
    bit got;
    n = 0;
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    while (!(q.size() == 3 && m_fly) && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL redir_setup_count got %0d exp 3", fifo_count); end
    step(1'b0, 1'b1, 1'b1, 32'h0000_0043);
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", inst_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req got %b exp 0", imem_req); end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL redir_flush got %0d exp 0", fifo_count); end
    checks++; if (imem_addr !== 6'h10) begin errors++; $display("FAIL redir_addr got %0d exp 16", imem_addr); end
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (inst_valid) got = 1'b1;
      else step(1'b0, 1'b1, 1'b0, 32'h0);
    end
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL redir_timeout got %b exp 1", got); end
    checks++; if (inst_pc !== 32'h40) begin errors++; $display("FAIL redir_pc got %h exp 00000040", inst_pc); end
    checks++; if (inst_code !== mem[16]) begin errors++; $display("FAIL redir_code got %h exp %h", inst_code, mem[16]); end
  endtask

  task automatic test_hold();
    logic [31:0] prev;
    bit have_prev;
    bit h;
    bit rd;
    have_prev = 1'b0;
    prev = '0;
    for (int i = 0; i < 30; i++) begin
      h = (i >= 4 && i <= 8);
      rd = (i >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
      step(h, rd, 1'b0, 32'h0);
      checks++; if (imem_req !== exp_req()) begin errors++; $display("FAIL hold_req got %b exp %b", imem_req, exp_req()); end
      if (i >= 5 && i <= 9) begin
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_no_req got %b exp 0", imem_req); end
      end
      if (inst_valid && inst_ready) begin
        if (have_prev) begin
          checks++; if (inst_pc !== prev + 32'd4) begin errors++; $display("FAIL hold_seq got %h exp %h", inst_pc, prev + 32'd4); end
        end
        prev = inst_pc;
        have_prev = 1'b1;
      end
    end
  endtask

  task automatic test_wrap();
    logic [5:0]  addrs [3];
    logic [31:0] pcs [3];
    logic [31:0] codes [3];
    logic [5:0]  exp_addr [3];
    logic [31:0] exp_pc [3];
    int na;
    int np;
    exp_addr = '{6'd62, 6'd63, 6'd0};
    exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    na = 0;
    np = 0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (w_count !== 3'd0) begin errors++; $display("FAIL wrap_rst_count got %0d exp 0", w_count); end
    checks++; if (w_valid !== 1'b0) begin errors++; $display("FAIL wrap_rst_valid got %b exp 0", w_valid); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      if (w_req && na < 3) begin addrs[na] = w_addr; na++; end
      if (w_valid && np < 3) begin pcs[np] = w_pc; codes[np] = w_code; np++; end
    end
    checks++; if (np !== 3) begin errors++; $display("FAIL wrap_count got %0d exp 3", np); end
    for (int i = 0; i < 3 && i < np && i < na; i++) begin
      checks++; if (addrs[i] !== exp_addr[i]) begin errors++; $display("FAIL wrap_addr got %0d exp %0d", addrs[i], exp_addr[i]); end
      checks++; if (pcs[i] !== exp_pc[i]) begin errors++; $display("FAIL wrap_pc got %h exp %h", pcs[i], exp_pc[i]); end
      checks++; if (codes[i] !== (32'hA000_0000 | 32'(exp_addr[i]))) begin errors++; $display("FAIL wrap_code got %h exp %h", codes[i], 32'hA000_0000 | 32'(exp_addr[i])); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    int lat;
    n = 0;
    step(1'b0, 1'b1, 1'b1, 32'h0000_0100);
    while (!(q.size() == 2 && m_fly) && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL arst_setup got %0d exp 2", fifo_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL arst_req got %b exp 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", inst_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", fifo_count); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL arst_pc got %h exp 0", inst_pc); end
    checks++; if (inst_code !== 32'h0) begin errors++; $display("FAIL arst_code got %h exp 0", inst_code); end
    @(negedge clk);
    reset = 1'b1;
    inst_ready = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk); #1;
      if (inst_valid) lat = k;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL arst_restart_edge got %0d exp 3", lat); end
    checks++; if (inst_pc !== 32'h0) begin errors++; $display("FAIL arst_restart_pc got %h exp 0", inst_pc); end
  endtask

  task automatic test_random();
    ent_t e;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 250; i++) begin
      step(($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 19) == 0), $urandom);
      e = exp_head();
      checks++; if (imem_req !== exp_req()) begin errors++; $display("FAIL rnd_req got %b exp %b", imem_req, exp_req()); end
      if (exp_req()) begin
        checks++; if (imem_addr !== m_pc[7:2]) begin errors++; $display("FAIL rnd_addr got %0d exp %0d", imem_addr, m_pc[7:2]); end
      end
      checks++; if (inst_valid !== exp_valid()) begin errors++; $display("FAIL rnd_valid got %b exp %b", inst_valid, exp_valid()); end
      checks++; if (fifo_count !== 3'(q.size())) begin errors++; $display("FAIL rnd_count got %0d exp %0d", fifo_count, q.size()); end
      checks++; if (inst_pc !== e.pc) begin errors++; $display("FAIL rnd_pc got %h exp %h", inst_pc, e.pc); end
      checks++; if (inst_code !== e.code) begin errors++; $display("FAIL rnd_code got %h exp %h", inst_code, e.code); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 | 32'(i);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
